mac_accumulator: RTL and testbench

Signed partial-sum accumulator for the MAC datapath. It takes a stream of 16-bit two's-complement products from the multiplier stage over a valid/ready handshake and folds each one into a running 16-bit sum. Each add is one 16-bit add with carry-in 0. When the beat flagged `in_last` is accepted, the block presents the finished dot-product sum, a beat count and an overflow flag to the downstream output/activation stage over a second valid/ready handshake.

---
 rtl/mac_accumulator.sv | 108 ++++++++++
 tb/tb_mac_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Signed 16-bit partial-sum accumulator with valid/ready in and out, beat counter and sticky overflow.
// Optional macro MAC_ACC_SAT_EN: clamp the accumulator on signed overflow instead of wrapping.
module mac_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [15:0]      acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic        accept;
   logic [15:0] sum;
   logic        beatOvf;
   logic [15:0] accNext;

   assign in_ready  = (state_q != DONE) && !clear;
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;

   assign sum     = acc_q + in_data;
   assign beatOvf = (acc_q[15] == in_data[15]) && (sum[15] != acc_q[15]);

`ifdef MAC_ACC_SAT_EN
   // Both operands share a sign on overflow, so acc_q[15] tells the overflow direction.
   assign accNext = beatOvf ? (acc_q[15] ? 16'h8000 : 16'h7FFF) : sum;
`else
   assign accNext = sum;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACC: begin
               if (accept) begin
                  acc_d   = accNext;
                  cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                  ovf_d   = ovf_q | beatOvf;
                  state_d = in_last ? DONE : ACC;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator; a second instance with CNT_W=2 covers count saturation.
module tb_mac_accumulator;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_ovf;
   logic [7:0]  out_count;

   logic        inValid2;
   logic        inReady2;
   logic [15:0] inData2;
   logic        inLast2;
   logic        outValid2;
   logic        outReady2;
   logic [15:0] outSum2;
   logic        outOvf2;
   logic [1:0]  outCount2;

   int checkCount;
   int passCount;

   mac_accumulator #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_ovf(out_ovf), .out_count(out_count)
   );

   mac_accumulator #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2), .in_last(inLast2),
      .out_valid(outValid2), .out_ready(outReady2), .out_sum(outSum2),
      .out_ovf(outOvf2), .out_count(outCount2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      else
         passCount++;
   endtask

   // Presents one beat for exactly one edge; called just after an edge while the DUT can accept.
   task automatic applyStimulus(input logic [15:0] data, input logic last);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic checkResult(input string tag, input logic [15:0] sum, input logic [7:0] count,
                              input logic ovf);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_sum"},   32'(out_sum),   32'(sum));
      checkOutput({tag, "_count"}, 32'(out_count), 32'(count));
      checkOutput({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
   endtask

   task automatic drainResult(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_idleRdy"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      clear      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      out_ready  = 1'b0;
      inValid2   = 1'b0;
      inData2    = '0;
      inLast2    = 1'b0;
      outReady2  = 1'b0;

      // Random traffic while held in reset must not be accepted.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 16'($urandom);
         in_last   = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
      end
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_ready", 32'(in_ready),  32'd1);
      checkOutput("rst_sum",   32'(out_sum),   32'd0);
      checkOutput("rst_count", 32'(out_count), 32'd0);
      checkOutput("rst_ovf",   32'(out_ovf),   32'd0);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;

      // Basic dot product
      applyStimulus(16'd3, 1'b0);
      applyStimulus(-16'sd5, 1'b0);
      checkOutput("basic_midValid", 32'(out_valid), 32'd0);
      applyStimulus(16'd10, 1'b1);
      checkResult("basic", 16'd8, 8'd3, 1'b0);
      checkOutput("basic_doneRdy", 32'(in_ready), 32'd0);
      drainResult("basic");

      // Positive overflow
      applyStimulus(16'h7000, 1'b0);
      applyStimulus(16'h2000, 1'b1);
`ifdef MAC_ACC_SAT_EN
      checkResult("posOvf", 16'h7FFF, 8'd2, 1'b1);
`else
      checkResult("posOvf", 16'h9000, 8'd2, 1'b1);
`endif
      drainResult("posOvf");

      // Negative overflow
      applyStimulus(16'h8000, 1'b0);
      applyStimulus(16'hFFFF, 1'b1);
`ifdef MAC_ACC_SAT_EN
      checkResult("negOvf", 16'h8000, 8'd2, 1'b1);
`else
      checkResult("negOvf", 16'h7FFF, 8'd2, 1'b1);
`endif
      drainResult("negOvf");

      // Backpressure in DONE with a beat waiting upstream
      applyStimulus(16'd1, 1'b0);
      applyStimulus(16'd2, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'd100;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("bp_inReady", 32'(in_ready), 32'd0);
         checkResult("bp", 16'd3, 8'd2, 1'b0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      drainResult("bp");
      applyStimulus(16'd4, 1'b1);
      checkResult("bpNext", 16'd4, 8'd1, 1'b0);
      drainResult("bpNext");

      // Clear after two beats, with a beat presented alongside clear
      applyStimulus(16'd5, 1'b0);
      applyStimulus(16'd6, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'd7;
      #1;
      checkOutput("clrMid_inReady", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      checkOutput("clrMid_valid", 32'(out_valid), 32'd0);
      checkOutput("clrMid_count", 32'(out_count), 32'd0);
      checkOutput("clrMid_sum",   32'(out_sum),   32'd0);
      applyStimulus(16'd9, 1'b1);
      checkResult("clrMidNext", 16'd9, 8'd1, 1'b0);

      // Clear while a result is pending in DONE
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'd50;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      checkOutput("clrDone_valid", 32'(out_valid), 32'd0);
      checkOutput("clrDone_sum",   32'(out_sum),   32'd0);
      applyStimulus(16'd2, 1'b1);
      checkResult("clrDoneNext", 16'd2, 8'd1, 1'b0);
      drainResult("clrDoneNext");

      // Single beat
      applyStimulus(16'hFFFF, 1'b1);
      checkResult("single", 16'hFFFF, 8'd1, 1'b0);

      // Async reset while the result is pending drops out_valid without a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRst_valid", 32'(out_valid), 32'd0);
      checkOutput("asyncRst_sum",   32'(out_sum),   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Count saturation on the narrow instance
      for (int i = 0; i < 5; i++) begin
         inValid2 = 1'b1;
         inData2  = 16'd1;
         inLast2  = (i == 4);
         @(posedge clk);
         #1;
      end
      inValid2 = 1'b0;
      inLast2  = 1'b0;
      checkOutput("sat_valid", 32'(outValid2), 32'd1);
      checkOutput("sat_count", 32'(outCount2), 32'd3);
      checkOutput("sat_sum",   32'(outSum2),   32'd5);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
